coord_uart_tx: RTL and testbench
================================

COORD_UART_TX -- requirements
Module: coord_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hA5, first byte of every frame.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 x_coor  input  10  target centroid x, sampled with coor_valid_flag.
REQ-006 y_coor  input  10  target centroid y, sampled with coor_valid_flag.
REQ-007 coor_valid_flag  input  1  one-cycle strobe marking x_coor/y_coor valid.
REQ-008 tx  output  1  UART serial line, idle high.
REQ-009 busy  output  1  high while a frame is being shifted out.
REQ-010 frame_done  output  1  one-cycle pulse after the last stop bit of a frame.
REQ-011 drop_cnt  output  8  count of coordinate samples overwritten before transmission.

Function
REQ-012 Frame is 6 bytes in order: HEADER, {6'b0,x[9:8]}, x[7:0], {6'b0,y[9:8]}, y[7:0], CHK.
REQ-013 CHK shall equal the sum of bytes 2..5, modulo 256 (carry discarded); HEADER is excluded.
REQ-014 Each byte is one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly BAUD_DIV cycles; no gap between bytes.
REQ-015 FSM states: IDLE, START, DATA, STOP; a 3-bit byte index (0..5) and a 3-bit bit index (0..7) are kept.
REQ-016 IDLE: tx=1, busy=0; if a sample is pending, load it into the shift frame, clear pending, go START.
REQ-017 START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
REQ-018 DATA: tx=current data bit; after BAUD_DIV cycles advance bit index; after bit 7 go STOP.
REQ-019 STOP: tx=1 for BAUD_DIV cycles; then if byte index<5 increment and go START, else go IDLE and pulse frame_done.
REQ-020 Capture: a strobe in any state writes x/y into a one-deep pending register and sets pending.
REQ-021 Strobe while pending already set: pending data overwritten with newest sample, drop_cnt increments, saturating at 255.
REQ-022 Strobe in the same cycle IDLE loads pending: the new strobe becomes the pending sample; the loaded frame is unaffected; no drop counted.
REQ-023 Latency: strobe at cycle N with FSM in IDLE and nothing pending -> tx falls at cycle N+2 (capture N+1, load/START N+2); busy rises same cycle as tx falls.
REQ-024 Frame duration 60*BAUD_DIV cycles from tx falling to frame_done pulse.
REQ-025 Frame content is frozen at load; input changes during a frame do not alter transmitted bytes.
REQ-026 Back-to-back: if pending is set at end of STOP of byte 5, next frame's start bit begins 1 cycle after frame_done (one IDLE cycle).
REQ-027 tx shall be driven from a register (glitch-free).

Reset
REQ-028 While rst=1 at a clock edge: state IDLE, tx=1, busy=0, frame_done=0, drop_cnt=0, pending cleared, all counters 0.
REQ-029 rst asserted mid-frame aborts the frame immediately; tx returns high on the next edge; no frame_done.
REQ-030 A strobe coincident with rst is discarded.

Verification (BAUD_DIV=4 unless noted)
REQ-031 Single frame: strobe x=300 (0x12C), y=240 (0x0F0) -> bytes A5,01,2C,00,F0,1D decoded; frame_done 240 cycles after tx falls.
REQ-032 Latency/timing: strobe at cycle 10 from idle -> tx low at cycle 12; every bit exactly 4 cycles wide, measured at all 60 bit boundaries.
REQ-033 Overwrite: during frame send strobes (1,2),(3,4),(5,6) -> next frame carries x=5,y=6, CHK=0x0B; drop_cnt=2.
REQ-034 Saturation: 300 strobes while busy with pending held -> drop_cnt=255, no wrap.
REQ-035 Reset mid-frame: rst for 1 cycle during byte 3 -> tx=1 next cycle, busy=0, drop_cnt=0, no frame_done; subsequent strobe yields a clean full frame.
REQ-036 Checksum carry: x=0x3FF, y=0x3FF -> bytes A5,03,FF,03,FF,04.

Source files
------------

// File: rtl/coord_uart_tx.sv
// Serialises captured (x, y) centroid samples as 6-byte UART frames:
// header, x hi, x lo, y hi, y lo, checksum. One-deep pending buffer with drop counting.
module coord_uart_tx #(
   parameter int         BAUD_DIV = 434,
   parameter logic [7:0] HEADER   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_coor,
   input  logic [9:0] y_coor,
   input  logic       coor_valid_flag,
   output logic       tx,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   state_t      r_state;
   logic [15:0] r_baud;
   logic [2:0]  r_byte_idx;
   logic [2:0]  r_bit_idx;
   logic        r_pend;
   logic [9:0]  r_pend_x;
   logic [9:0]  r_pend_y;
   logic [9:0]  r_frm_x;
   logic [9:0]  r_frm_y;
   logic [7:0]  r_chk;
   logic        r_tx;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  r_drop;

   logic        w_baud_end;
   logic [7:0]  w_cur_byte;
   logic [7:0]  w_chk;
   logic [2:0]  w_next_bit;
   logic        w_load;

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_next_bit = r_bit_idx + 3'd1;
   assign w_load     = (r_state == IDLE) && r_pend;
   // Checksum is fixed at load time so the frame is immune to later captures.
   assign w_chk      = {6'b0, r_pend_x[9:8]} + r_pend_x[7:0]
                     + {6'b0, r_pend_y[9:8]} + r_pend_y[7:0];

   always_comb begin
      w_cur_byte = HEADER;
      case (r_byte_idx)
         3'd1:    w_cur_byte = {6'b0, r_frm_x[9:8]};
         3'd2:    w_cur_byte = r_frm_x[7:0];
         3'd3:    w_cur_byte = {6'b0, r_frm_y[9:8]};
         3'd4:    w_cur_byte = r_frm_y[7:0];
         3'd5:    w_cur_byte = r_chk;
         default: w_cur_byte = HEADER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baud     <= '0;
         r_byte_idx <= '0;
         r_bit_idx  <= '0;
         r_pend     <= 1'b0;
         r_pend_x   <= '0;
         r_pend_y   <= '0;
         r_frm_x    <= '0;
         r_frm_y    <= '0;
         r_chk      <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_drop     <= '0;
      end else begin
         r_done <= 1'b0;

         // A strobe always wins the pending slot; IDLE consuming it is not a drop.
         if (coor_valid_flag) begin
            r_pend   <= 1'b1;
            r_pend_x <= x_coor;
            r_pend_y <= y_coor;
            if (r_pend && (r_state != IDLE) && (r_drop != 8'hFF))
               r_drop <= r_drop + 8'd1;
         end else if (w_load) begin
            r_pend <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (r_pend) begin
                  r_frm_x    <= r_pend_x;
                  r_frm_y    <= r_pend_y;
                  r_chk      <= w_chk;
                  r_byte_idx <= '0;
                  r_bit_idx  <= '0;
                  r_baud     <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= w_cur_byte[0];
                  r_state   <= DATA;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= w_next_bit;
                     r_tx      <= w_cur_byte[w_next_bit];
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_byte_idx < 3'd5) begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                     r_tx       <= 1'b0;
                     r_state    <= START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign frame_done = r_done;
   assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_coord_uart_tx.sv
// Randomised bench for coord_uart_tx: a frame-timeline reference model predicts
// the line level, busy, frame_done and drop count every cycle; frames are decoded too.
module tb_coord_uart_tx;
   localparam int         B   = 4;
   localparam logic [7:0] HDR = 8'hA5;

   logic       clk = 1'b0;
   logic       rst, stb;
   logic [9:0] xi, yi;
   logic       tx, busy, done;
   logic [7:0] drop;

   coord_uart_tx #(.BAUD_DIV(B), .HEADER(HDR)) dut (
      .clk(clk), .rst(rst), .x_coor(xi), .y_coor(yi), .coor_valid_flag(stb),
      .tx(tx), .busy(busy), .frame_done(done), .drop_cnt(drop)
   );

   always #5 clk = ~clk;

   int   n_vec = 0, n_miss = 0, cyc = 0, n_frames = 0;
   bit   m_pend = 0, m_active = 0;
   int   m_px = 0, m_py = 0, m_drop = 0, m_L = 0, m_end = 0;
   int   m_bytes[6];
   logic dec_bits[60];
   logic [7:0] last_frame[6];
   int   cap_cyc = 0, fall_cyc = 0, done_cyc = 0;
   logic prev_busy = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Frame timeline: loaded at edge L, line busy for 60 bit times, done pulse after edge L+60*B,
   // IDLE acts again from the following edge.
   task automatic model_step(input bit s, input int x, input int y, input bit r);
      bit idle, load;
      if (r) begin
         m_pend = 0; m_drop = 0; m_active = 0;
         return;
      end
      idle = !m_active || (cyc > m_end);
      load = idle && m_pend;
      if (s && m_pend && !idle && m_drop < 255) m_drop++;
      if (load) begin
         m_bytes[0] = HDR;
         m_bytes[1] = m_px / 256;
         m_bytes[2] = m_px % 256;
         m_bytes[3] = m_py / 256;
         m_bytes[4] = m_py % 256;
         m_bytes[5] = (m_bytes[1] + m_bytes[2] + m_bytes[3] + m_bytes[4]) % 256;
         m_L = cyc; m_end = cyc + 60 * B; m_active = 1;
      end
      if (s) begin
         m_pend = 1; m_px = x; m_py = y;
      end else if (load) begin
         m_pend = 0;
      end
   endtask

   task automatic check_outputs();
      int k, bitn, pos, etx;
      bit ebusy, edone;
      etx = 1; ebusy = 0; edone = 0;
      if (m_active && cyc >= m_L && cyc < m_end) begin
         k = cyc - m_L; bitn = k / B; pos = bitn % 10; ebusy = 1;
         if (pos == 0)      etx = 0;
         else if (pos == 9) etx = 1;
         else               etx = (m_bytes[bitn / 10] >> (pos - 1)) & 1;
         if (k % B == B / 2) dec_bits[bitn] = tx;
      end else if (m_active && cyc == m_end) begin
         edone = 1;
      end
      check_eq("tx", tx, etx);
      check_eq("busy", busy, ebusy);
      check_eq("frame_done", done, edone);
      check_eq("drop_cnt", drop, m_drop);
      if (prev_busy !== 1'b1 && busy === 1'b1) fall_cyc = cyc;
      if (done === 1'b1) done_cyc = cyc;
      prev_busy = busy;
      if (edone) begin
         for (int i = 0; i < 6; i++)
            for (int b = 0; b < 8; b++) last_frame[i][b] = dec_bits[i * 10 + 1 + b];
         n_frames++;
         $display("frame %0d @%0d: %02h %02h %02h %02h %02h %02h (model x=%0d y=%0d)",
                  n_frames, cyc, last_frame[0], last_frame[1], last_frame[2],
                  last_frame[3], last_frame[4], last_frame[5],
                  m_bytes[1] * 256 + m_bytes[2], m_bytes[3] * 256 + m_bytes[4]);
      end
   endtask

   task automatic cycle(input bit s, input int x, input int y, input bit r);
      rst = r; stb = s; xi = x[9:0]; yi = y[9:0];
      @(posedge clk);
      cyc++;
      if (s && !r) cap_cyc = cyc;
      model_step(s, x, y, r);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_cycle();
      cycle(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_active && cyc <= m_end) || m_pend) begin
         if (n >= 2000) begin
            n_vec++; n_miss++;
            $display("FAIL wait_idle: frame still pending after %0d cycles", n);
            break;
         end
         idle_cycle();
         n++;
      end
   endtask

   task automatic check_frame(input string tag, input int b0, input int b1, input int b2,
                              input int b3, input int b4, input int b5);
      int e[6];
      e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4; e[5] = b5;
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("%s_byte%0d", tag, i), last_frame[i], e[i]);
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; xi = '0; yi = '0;
      @(negedge clk);
      repeat (3) cycle(0, 0, 0, 1);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_drop", drop, 0);

      // single frame, latency and duration
      repeat (6) idle_cycle();
      cycle(1, 300, 240, 0);
      wait_idle();
      check_eq("latency", fall_cyc - cap_cyc, 1);
      check_eq("duration", done_cyc - fall_cyc, 60 * B);
      check_frame("single", 'hA5, 'h01, 'h2C, 'h00, 'hF0, 'h1D);

      // checksum carry discarded
      cycle(1, 'h3FF, 'h3FF, 0);
      wait_idle();
      check_frame("carry", 'hA5, 'h03, 'hFF, 'h03, 'hFF, 'h04);

      // overwrite of pending sample during a frame
      cycle(1, 100, 200, 0);
      repeat (20) idle_cycle();
      cycle(1, 1, 2, 0);
      repeat (10) idle_cycle();
      cycle(1, 3, 4, 0);
      repeat (10) idle_cycle();
      cycle(1, 5, 6, 0);
      wait_idle();
      check_eq("overwrite_drops", drop, 2);
      check_frame("overwrite", 'hA5, 'h00, 'h05, 'h00, 'h06, 'h0B);

      // reset in the middle of byte 3
      cycle(1, 55, 66, 0);
      idle_cycle();
      while (cyc < m_L + 3 * 10 * B + 10) idle_cycle();
      cycle(0, 0, 0, 1);
      check_eq("midrst_tx", tx, 1);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_drop", drop, 0);
      check_eq("midrst_done", done, 0);
      repeat (3) idle_cycle();
      cycle(1, 'h2AB, 'h155, 0);
      wait_idle();
      check_frame("after_rst", 'hA5, 'h02, 'hAB, 'h01, 'h55, 'h03);

      // drop counter saturation
      cycle(0, 0, 0, 1);
      for (int i = 0; i < 600; i++) cycle(1, $urandom_range(0, 1023), $urandom_range(0, 1023), 0);
      check_eq("saturation", drop, 255);
      wait_idle();

      // random traffic with occasional resets (including strobes coincident with reset)
      for (int i = 0; i < 4000; i++)
         cycle($urandom_range(0, 99) < 2, $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1499) == 0);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
